// File: rtl/dct_stage4_pipe.sv
// rtl/dct_stage4_pipe.sv - final 8-point DCT butterfly stage with saturation, back-pressure and status
module dct_stage4_pipe #(
    parameter int                DATA_W     = 32,
    parameter int                FRAC_W     = 16,
    parameter logic [DATA_W-1:0] COEF       = DATA_W'(32'h00016A0A),
    parameter int                PIPE_DEPTH = 2,
    parameter bit                SAT        = 1'b1,
    parameter int                CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [8*DATA_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*DATA_W-1:0] out_data,
    input  logic                clr_stat,
    output logic                sat_flag,
    output logic [CNT_W-1:0]    blk_cnt
);

    localparam int LW = 8 * DATA_W;
    localparam int WW = 2 * DATA_W + 1;
    localparam logic signed [WW-1:0] MAX_V = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [WW-1:0] MIN_V = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [WW-1:0] RND_V = WW'(1) << (FRAC_W - 1);

    // Returns {saturated, value}; wrap mode never reports saturation.
    function automatic logic [DATA_W:0] reduce(input logic signed [WW-1:0] v);
        logic hi;
        logic lo;
        hi = (v > MAX_V);
        lo = (v < MIN_V);
        if (SAT && hi) return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        if (SAT && lo) return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        return {1'b0, v[DATA_W-1:0]};
    endfunction

    logic signed [DATA_W-1:0] o4, o5, o6, o7;
    assign o4 = in_data[4*DATA_W +: DATA_W];
    assign o5 = in_data[5*DATA_W +: DATA_W];
    assign o6 = in_data[6*DATA_W +: DATA_W];
    assign o7 = in_data[7*DATA_W +: DATA_W];

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic                       s1_valid;
    logic                       s1_mode;
    logic [LW-1:0]              s1_lanes;
    logic signed [DATA_W:0]     s1_sum;
    logic signed [DATA_W:0]     s1_dif;
    logic signed [2*DATA_W-1:0] s1_p5;
    logic signed [2*DATA_W-1:0] s1_p6;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_lanes <= '0;
            s1_sum   <= '0;
            s1_dif   <= '0;
            s1_p5    <= '0;
            s1_p6    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_mode  <= in_mode;
            s1_lanes <= in_data;
            s1_sum   <= {o4[DATA_W-1], o4} + {o7[DATA_W-1], o7};
            s1_dif   <= {o7[DATA_W-1], o7} - {o4[DATA_W-1], o4};
            s1_p5    <= (2*DATA_W)'(o5) * (2*DATA_W)'($signed(COEF));
            s1_p6    <= (2*DATA_W)'(o6) * (2*DATA_W)'($signed(COEF));
        end
    end

    logic signed [WW-1:0] w_p5, w_p6;
    logic [DATA_W:0]      r_sum, r_dif, r_p5, r_p6;
    logic [LW-1:0]        s2_next;
    logic                 s2_sat;

    always_comb begin
        w_p5    = (WW'(s1_p5) + RND_V) >>> FRAC_W;
        w_p6    = (WW'(s1_p6) + RND_V) >>> FRAC_W;
        r_sum   = reduce(WW'(s1_sum));
        r_dif   = reduce(WW'(s1_dif));
        r_p5    = reduce(w_p5);
        r_p6    = reduce(w_p6);
        s2_next = s1_lanes;
        if (!s1_mode) begin
            // Output order D0..D7 = O0, sum, O2, O5*c, O1, O6*c, O3, diff
            s2_next[1*DATA_W +: DATA_W] = r_sum[DATA_W-1:0];
            s2_next[3*DATA_W +: DATA_W] = r_p5[DATA_W-1:0];
            s2_next[4*DATA_W +: DATA_W] = s1_lanes[1*DATA_W +: DATA_W];
            s2_next[5*DATA_W +: DATA_W] = r_p6[DATA_W-1:0];
            s2_next[6*DATA_W +: DATA_W] = s1_lanes[3*DATA_W +: DATA_W];
            s2_next[7*DATA_W +: DATA_W] = r_dif[DATA_W-1:0];
        end
        s2_sat = s1_valid && !s1_mode && (r_sum[DATA_W] || r_dif[DATA_W] || r_p5[DATA_W] || r_p6[DATA_W]);
    end

    logic [LW-1:0]       st_data [2:PIPE_DEPTH];
    logic [PIPE_DEPTH:2] st_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_valid <= '0;
            for (int i = 2; i <= PIPE_DEPTH; i++) st_data[i] <= '0;
        end else if (adv) begin
            st_valid[2] <= s1_valid;
            st_data[2]  <= s2_next;
            for (int i = 3; i <= PIPE_DEPTH; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_data[i]  <= st_data[i-1];
            end
        end
    end

    assign out_valid = st_valid[PIPE_DEPTH];
    assign out_data  = st_data[PIPE_DEPTH];

    logic out_hs;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
            blk_cnt  <= '0;
        end else begin
            if (adv && s2_sat) sat_flag <= 1'b1;
            else if (clr_stat) sat_flag <= 1'b0;
            if (clr_stat)      blk_cnt  <= CNT_W'(out_hs);
            else if (out_hs)   blk_cnt  <= blk_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dct_stage4_pipe.sv
// tb/tb_dct_stage4_pipe.sv - randomized bench for dct_stage4_pipe against a queue-based reference model
module tb_dct_stage4_pipe;

    localparam int     DW     = 32;
    localparam int     PD     = 2;
    localparam longint COEF_L = 64'sh16A0A;
    localparam longint MAX_L  = 64'sh7FFFFFFF;
    localparam longint MIN_L  = -64'sh80000000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0, clr_stat = 1'b0;
    logic [8*DW-1:0] in_data = '0;
    logic           in_ready, out_valid, sat_flag;
    logic [8*DW-1:0] out_data;
    logic [15:0]    blk_cnt;
    logic           w_in_ready, w_out_valid, w_sat_flag;
    logic [8*DW-1:0] w_out_data;
    logic [1:0]     w_blk_cnt;

    always #5 clk = ~clk;

    dct_stage4_pipe #(.DATA_W(DW), .FRAC_W(16), .COEF(32'h00016A0A), .PIPE_DEPTH(PD), .SAT(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .clr_stat(clr_stat), .sat_flag(sat_flag), .blk_cnt(blk_cnt));

    dct_stage4_pipe #(.DATA_W(DW), .FRAC_W(16), .COEF(32'h00016A0A), .PIPE_DEPTH(PD), .SAT(1'b0), .CNT_W(2)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .clr_stat(clr_stat), .sat_flag(w_sat_flag), .blk_cnt(w_blk_cnt));

    typedef struct {
        bit           valid;
        bit           flag;
        logic [255:0] d_sat;
        logic [255:0] d_wrap;
    } beat_t;

    beat_t pipe_q [$];
    bit    exp_sat;
    int    exp_cnt, exp_wcnt;
    int    n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic logic [32:0] fit(input longint v, input bit sat);
        logic [63:0] t;
        t = v;
        if (v > MAX_L && sat) return {1'b1, 32'h7FFFFFFF};
        if (v < MIN_L && sat) return {1'b1, 32'h80000000};
        return {1'b0, t[31:0]};
    endfunction

    function automatic void ref_beat(input logic [255:0] d, input bit m, input bit sat,
                                     output logic [255:0] r, output bit flag);
        longint      o [8];
        logic [31:0] lane;
        logic [32:0] f [4];
        flag = 1'b0;
        r    = d;
        if (m) return;
        for (int k = 0; k < 8; k++) begin
            lane = d[k*32 +: 32];
            o[k] = $signed(lane);
        end
        f[0] = fit(o[4] + o[7], sat);
        f[1] = fit(o[7] - o[4], sat);
        f[2] = fit((o[5] * COEF_L + 64'sd32768) >>> 16, sat);
        f[3] = fit((o[6] * COEF_L + 64'sd32768) >>> 16, sat);
        r[0*32 +: 32] = d[0*32 +: 32];
        r[4*32 +: 32] = d[1*32 +: 32];
        r[2*32 +: 32] = d[2*32 +: 32];
        r[6*32 +: 32] = d[3*32 +: 32];
        r[1*32 +: 32] = f[0][31:0];
        r[7*32 +: 32] = f[1][31:0];
        r[3*32 +: 32] = f[2][31:0];
        r[5*32 +: 32] = f[3][31:0];
        flag = f[0][32] | f[1][32] | f[2][32] | f[3][32];
    endfunction

    function automatic logic [255:0] vec8(input logic [31:0] l0, l1, l2, l3, l4, l5, l6, l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic model_reset();
        beat_t e;
        e.valid = 1'b0; e.flag = 1'b0; e.d_sat = '0; e.d_wrap = '0;
        pipe_q.delete();
        for (int i = 0; i < PD; i++) pipe_q.push_back(e);
        exp_sat  = 1'b0;
        exp_cnt  = 0;
        exp_wcnt = 0;
    endtask

    // One clock: check current outputs, drive new inputs, advance the model, wait for the next negedge.
    task automatic cycle(input bit v, input bit m, input logic [255:0] d, input bit ordy, input bit clr);
        beat_t last, first, nb;
        bit    outv, adv, hs, fw;
        last  = pipe_q[PD-1];
        first = pipe_q[0];
        outv  = last.valid;
        check("out_valid", 256'(out_valid), 256'(outv));
        check("w_out_valid", 256'(w_out_valid), 256'(outv));
        if (outv) begin
            check("out_data", out_data, last.d_sat);
            check("w_out_data", w_out_data, last.d_wrap);
        end
        check("sat_flag", 256'(sat_flag), 256'(exp_sat));
        check("w_sat_flag", 256'(w_sat_flag), 256'(0));
        check("blk_cnt", 256'(blk_cnt), 256'(exp_cnt));
        check("w_blk_cnt", 256'(w_blk_cnt), 256'(exp_wcnt));
        in_valid  = v;
        in_mode   = m;
        in_data   = d;
        out_ready = ordy;
        clr_stat  = clr;
        #1;
        adv = !outv || ordy;
        hs  = outv && ordy;
        check("in_ready", 256'(in_ready), 256'(adv));
        check("w_in_ready", 256'(w_in_ready), 256'(adv));
        exp_sat  = (clr ? 1'b0 : exp_sat) | (adv && first.valid && first.flag);
        exp_cnt  = clr ? int'(hs) : (exp_cnt + int'(hs)) % 65536;
        exp_wcnt = clr ? int'(hs) : (exp_wcnt + int'(hs)) % 4;
        if (adv) begin
            nb.valid = v;
            ref_beat(d, m, 1'b1, nb.d_sat, nb.flag);
            ref_beat(d, m, 1'b0, nb.d_wrap, fw);
            void'(pipe_q.pop_back());
            pipe_q.push_front(nb);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] d;
        logic [31:0]  lane;
        for (int k = 0; k < 8; k++) begin
            if ($urandom % 2) lane = $urandom;
            else lane = 32'($urandom_range(0, 2097152)) - 32'd1048576;
            d[k*32 +: 32] = lane;
        end
        return d;
    endfunction

    initial begin
        logic [255:0] bf_vec, sat_vec;
        int           sent, acc;
        bit           ordy;

        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data", out_data, 256'(0));
        check("rst_sat_flag", 256'(sat_flag), 256'(0));
        check("rst_blk_cnt", 256'(blk_cnt), 256'(0));
        reset = 1'b0;

        bf_vec = vec8(32'd1, 32'd2, 32'd3, 32'd4, 32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00020000);
        cycle(1'b1, 1'b0, bf_vec, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("tp_d1", 256'(out_data[1*32 +: 32]), 256'(32'h00030000));
        check("tp_d7", 256'(out_data[7*32 +: 32]), 256'(32'h00010000));
        check("tp_d3", 256'(out_data[3*32 +: 32]), 256'(32'h00016A0A));
        check("tp_d5", 256'(out_data[5*32 +: 32]), 256'(32'hFFFE95F6));
        check("tp_d4", 256'(out_data[4*32 +: 32]), 256'(32'd2));
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("tp_blk_cnt", 256'(blk_cnt), 256'(1));
        check("tp_sat_flag", 256'(sat_flag), 256'(0));

        sat_vec = vec8(32'd0, 32'd0, 32'd0, 32'd0, 32'h7FFF0000, 32'd0, 32'd0, 32'h7FFF0000);
        cycle(1'b1, 1'b0, sat_vec, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("sat_d1", 256'(out_data[1*32 +: 32]), 256'(32'h7FFFFFFF));
        check("sat_d7", 256'(out_data[7*32 +: 32]), 256'(32'd0));
        check("sat_flag_set", 256'(sat_flag), 256'(1));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, bf_vec, 1'b1, 1'b0);
        idle(2);
        check("sat_sticky", 256'(sat_flag), 256'(1));
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("sat_cleared", 256'(sat_flag), 256'(0));

        cycle(1'b1, 1'b1, sat_vec, 1'b1, 1'b0);
        idle(2);
        check("byp_sat_flag", 256'(sat_flag), 256'(0));
        for (int i = 0; i < 8; i++) cycle(1'b1, i[0], (i % 3 == 0) ? sat_vec : rand_vec(), 1'b1, 1'b0);
        idle(3);

        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            ordy = (i % 3 == 0);
            acc  = (!pipe_q[PD-1].valid || ordy) ? 1 : 0;
            cycle(sent < 10, 1'b0, rand_vec(), ordy, 1'b0);
            if (sent < 10 && acc == 1) sent++;
        end
        check("bp_blk_cnt", 256'(blk_cnt), 256'(10));

        cycle(1'b1, 1'b0, bf_vec, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, sat_vec, 1'b1, 1'b0);
        #1 reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", 256'(out_valid), 256'(0));
        check("mid_rst_blk_cnt", 256'(blk_cnt), 256'(0));
        check("mid_rst_sat_flag", 256'(sat_flag), 256'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 1'b0, bf_vec, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("post_rst_valid", 256'(out_valid), 256'(1));
        check("post_rst_d1", 256'(out_data[1*32 +: 32]), 256'(32'h00030000));
        idle(2);

        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, rand_vec(), 1'b1, 1'b0);
        idle(2);
        check("wrap_cnt", 256'(w_blk_cnt), 256'(1));
        cycle(1'b1, 1'b0, bf_vec, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("clr_hs_cnt", 256'(blk_cnt), 256'(1));
        check("clr_hs_wcnt", 256'(w_blk_cnt), 256'(1));

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, ($urandom % 4) == 0, rand_vec(), ($urandom % 4) != 0, ($urandom % 32) == 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dct_stage4_pipe.md
Name: dct_stage4_pipe

Overview:
- Parametrised fixed-point successor of the final DCT butterfly stage of the JPEG 8-point 1-D DCT.
- Takes one 8-lane vector per beat and produces the reordered stage-4 outputs.
- Uses signed fixed-point arithmetic with selectable saturation, full valid/ready back-pressure, a per-beat bypass mode and status counters.
- Sits between DCT stage 3 and the quantiser.

Parameters:
- DATA_W, 32: lane width, signed two's complement.
- FRAC_W, 16: fractional bits of lane data and COEF.
- COEF, 32'h00016A0A: sqrt(2) in Q(DATA_W-FRAC_W).FRAC_W, DATA_W bits wide.
- PIPE_DEPTH, 2: input-accept to output latency in cycles, >=2.
- SAT, 1: 1 = saturate on overflow, 0 = wrap.
- CNT_W, 16: width of blk_cnt.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: input beat accepted when in_valid & in_ready.
- in_mode, in, 1: 0 = butterfly, 1 = bypass; travels with the beat.
- in_data, in, 8*DATA_W: lane k (O_k) at [k*DATA_W +: DATA_W].
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accept.
- out_data, out, 8*DATA_W: lane k (D_k) at [k*DATA_W +: DATA_W].
- clr_stat, in, 1: synchronous clear of sat_flag and blk_cnt.
- sat_flag, out, 1: sticky, set when any lane of any accepted beat saturated.
- blk_cnt, out, CNT_W: count of output handshakes, wraps to 0 after 2^CNT_W-1.

Behaviour:
- Reset (async assert, sync deassert): out_valid=0, out_data=0, sat_flag=0, blk_cnt=0, all pipeline valids cleared. In-flight beats are discarded. in_ready=1 from the first clock after deassert.
- Butterfly mode (in_mode=0), per beat:
  - D0=O0, D4=O1, D2=O2, D6=O3.
  - D1=O4+O7, D7=O7-O4.
  - D3=O5*COEF, D5=O6*COEF.
- Bypass mode (in_mode=1): D_k=O_k for all k. Same latency. Never sets sat_flag.
- Add/sub: computed at DATA_W+1 bits, then reduced to DATA_W.
  - SAT=1: clamp to 0x7FF..F / 0x800..0 and flag.
  - SAT=0: truncate to the low DATA_W bits, no flag.
- Multiply:
  - Full 2*DATA_W signed product.
  - Add 1<<(FRAC_W-1), then arithmetic shift right FRAC_W (round half toward +inf).
  - Reduce to DATA_W as for add/sub.
- Pass-through lanes are delayed so all 8 lanes and mode stay aligned.
- Pipeline:
  - PIPE_DEPTH stage registers, each with a valid bit.
  - Stage 1 registers inputs and raw sums/products.
  - Stage 2 rounds and saturates.
  - Stages 3..PIPE_DEPTH are pure delay.
  - out_data/out_valid are driven from the last stage.
- Flow control:
  - adv = !out_valid | out_ready; in_ready = adv, combinational, no input-to-output comb path on data.
  - When adv=1, every stage shifts by one and stage 1 loads in_valid & in_ready.
  - When adv=0, all stages hold and out_data stays stable.
  - Bubbles are not compressed.
- Latency: with out_ready held 1, a beat accepted at edge N appears with out_valid=1 after edge N+PIPE_DEPTH-1. Full throughput is 1 beat/cycle.
- sat_flag:
  - Set on the edge stage 2 produces a saturated lane for a valid beat.
  - Cleared by clr_stat. If set and clear occur in the same cycle, the set wins.
- blk_cnt:
  - Increments on each out_valid & out_ready.
  - On clr_stat, loads 0, or 1 if a handshake occurs in the same cycle.
- Reset mid-stream: flushes all state. No partial beat emerges after reset.

Test Plan:
- Butterfly, Q16.16, O4=0x00010000, O7=0x00020000, O5=0x00010000, O6=0xFFFF0000, O0..O3=1,2,3,4, out_ready=1 -> after PIPE_DEPTH cycles:
  - D1=0x00030000, D7=0x00010000, D3=0x00016A0A, D5=0xFFFE95F6.
  - D0=1, D4=2, D2=3, D6=4; sat_flag=0; blk_cnt=1.
- Saturation, SAT=1, O4=O7=0x7FFF0000 -> D1=0x7FFFFFFF, D7=0, sat_flag=1. Holds after further clean beats until clr_stat.
- Bypass: in_mode=1 with the same vector as the saturation test -> D_k=O_k exactly, sat_flag stays 0. Alternating mode per beat gives correct per-beat results.
- Back-pressure: stream 10 beats with out_ready toggling 1,0,0,1,... ->
  - No beat lost or duplicated, order preserved.
  - out_data stable while out_valid & !out_ready.
  - blk_cnt=10.
- Reset with 2 beats in flight -> out_valid=0 and blk_cnt=0 immediately. The next accepted beat emerges exactly PIPE_DEPTH cycles later with correct data.
- Wrap, CNT_W=2: 5 handshakes -> blk_cnt=1. clr_stat coincident with a handshake -> blk_cnt=1.
